// File: rtl/swsd_frame_ctrl.sv
// Frame sequencer for one sliding-window detector: clear, shift MSB first, count hits, report (SWSD_CTRL_HITMAP_EN adds res_hitmap).
// Latency len+2 cycles from accept to res_valid (1 for len=0); the result is held until res_ready, and frm_ready stays low until then.
module swsd_frame_ctrl #(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frm_valid,
  output logic          frm_ready,
  input  logic [W-1:0]  frm_data,
  input  logic [CW-1:0] frm_len,
  output logic          det_rst_n,
  output logic          det_in,
  input  logic          det_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_hits,
  output logic [CW-1:0] res_first,
`ifdef SWSD_CTRL_HITMAP_EN
  output logic [W-1:0]  res_hitmap,
`endif
  output logic          res_any
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LEN_MAX = CW'(W);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] hits_q, hits_d;
  logic [CW-1:0] first_q, first_d;
  logic          any_q, any_d;
  logic [W-1:0]  hitmap_q, hitmap_d;
  logic          frm_ready_q, frm_ready_d;
  logic          det_rst_n_q, det_rst_n_d;
  logic          det_in_q, det_in_d;
  logic          res_valid_q, res_valid_d;
  logic [CW-1:0] len_clamped;

  assign len_clamped = (frm_len > LEN_MAX) ? LEN_MAX : frm_len;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    len_d    = len_q;
    idx_d    = idx_q;
    hits_d   = hits_q;
    first_d  = first_q;
    any_d    = any_q;
    hitmap_d = hitmap_q;
    case (state_q)
      IDLE: begin
        if (frm_valid && frm_ready_q) begin
          sr_d     = frm_data;
          len_d    = len_clamped;
          idx_d    = '0;
          hits_d   = '0;
          first_d  = '0;
          any_d    = 1'b0;
          hitmap_d = '0;
          state_d  = (len_clamped == '0) ? REPORT : CLEAR;
        end
      end
      CLEAR: state_d = SHIFT;
      SHIFT: begin
        // det_out is Mealy on det_in, so it is sampled at the edge closing this bit
        if (det_out) begin
          if (hits_q != '1) hits_d = hits_q + CW'(1);
          if (!any_q) begin
            first_d = idx_q;
            any_d   = 1'b1;
          end
          hitmap_d[idx_q[IW-1:0]] = 1'b1;
        end
        sr_d  = sr_q << 1;
        idx_d = idx_q + CW'(1);
        if (idx_q == len_q - CW'(1)) state_d = REPORT;
      end
      REPORT: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so they are decoded from the next state
    frm_ready_d = (state_d == IDLE);
    det_rst_n_d = (state_d != CLEAR);
    det_in_d    = (state_d == SHIFT) && sr_d[W-1];
    res_valid_d = (state_d == REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      hits_q      <= '0;
      first_q     <= '0;
      any_q       <= 1'b0;
      hitmap_q    <= '0;
      frm_ready_q <= 1'b0;
      det_rst_n_q <= 1'b0;
      det_in_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      hits_q      <= hits_d;
      first_q     <= first_d;
      any_q       <= any_d;
      hitmap_q    <= hitmap_d;
      frm_ready_q <= frm_ready_d;
      det_rst_n_q <= det_rst_n_d;
      det_in_q    <= det_in_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign frm_ready = frm_ready_q;
  assign det_rst_n = det_rst_n_q;
  assign det_in    = det_in_q;
  assign res_valid = res_valid_q;
  assign res_hits  = hits_q;
  assign res_first = first_q;
  assign res_any   = any_q;
`ifdef SWSD_CTRL_HITMAP_EN
  assign res_hitmap = hitmap_q;
`endif

endmodule
